// File: rtl/chia_xung_pkg.sv
`default_nettype none
// ============================================================================
// Module  : chia_xung_pkg
// Purpose : Shared constants, types and helpers for the chia_xung clock
//           divider: default clock/debounce settings, prescaler divide
//           derivation, counter-width helper and the phase encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package chia_xung_pkg;

  localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
  localparam int unsigned DEB_CYC_DEFAULT = 500_000;   // 10 ms at 50 MHz

  // The prescaler ticks at 20 Hz: four phases of 50 ms give 10 Hz and 5 Hz.
  localparam int unsigned TICK_HZ = 20;

  // Quarter-period phase of the 5 Hz output; bit 0 is clk10hz, bit 1 is clk5hz.
  typedef enum logic [1:0] {
    PH_LOW  = 2'd0,
    PH_10   = 2'd1,
    PH_5    = 2'd2,
    PH_BOTH = 2'd3
  } phase_e;

  function automatic int unsigned div_of(input int unsigned clk_hz);
    return clk_hz / TICK_HZ;
  endfunction

  // Minimum width able to hold n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    logic [1:0] v;
    v = p;
    v = v + 2'd1;
    return phase_e'(v);
  endfunction

  localparam int unsigned DIV_DEFAULT   = div_of(CLK_HZ_DEFAULT);
  localparam int unsigned DIV_W_DEFAULT = cnt_width(DIV_DEFAULT);
  localparam int unsigned DEB_W_DEFAULT = cnt_width(DEB_CYC_DEFAULT);

endpackage : chia_xung_pkg
`default_nettype wire

// File: rtl/chong_doi.sv
`default_nettype none
// ============================================================================
// Module  : chong_doi
// Purpose : Two-flop synchronizer followed by a counter debouncer. The
//           stable value only follows the synchronized input after it has
//           differed for DEB_CYC consecutive cycles.
// Ports   : clk   - system clock
//           rst   - synchronous active-high reset
//           d_in  - raw asynchronous input
//           d_out - debounced stable value (registered)
// Rev     : 1.0  initial release
// ============================================================================
module chong_doi
  import chia_xung_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  localparam int unsigned DEB_W = cnt_width(DEB_CYC);
  localparam logic [DEB_W-1:0] DCNT_LAST = DEB_W'(DEB_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic [DEB_W-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync1 <= d_in;
      sync2 <= sync1;
      if (sync2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        // Input has disagreed for the full window: accept it.
        deb  <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DEB_W'(1);
      end
    end
  end

  assign d_out = deb;

endmodule : chong_doi
`default_nettype wire

// File: rtl/chia_xung.sv
`default_nettype none
// ============================================================================
// Module  : chia_xung
// Purpose : Divides clk down to phase-aligned 10 Hz and 5 Hz square waves,
//           produces rising-edge tick pulses, and presents a debounced
//           frequency select that only changes while both clocks are low.
// Ports   : clk      - system clock
//           rst      - synchronous active-high reset
//           en       - run enable, 0 freezes waveform generation
//           frez_in  - raw select switch (0 = 5 Hz, 1 = 10 Hz)
//           clk10hz  - 10 Hz square wave, 50 % duty
//           clk5hz   - 5 Hz square wave, 50 % duty
//           tick10   - one-cycle pulse as clk10hz rises
//           tick5    - one-cycle pulse as clk5hz rises
//           frez     - debounced select, updated at the 3->0 phase wrap
// Rev     : 1.0  initial release
// ============================================================================
module chia_xung
  import chia_xung_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int unsigned DEB_CYC = DEB_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic frez_in,
  output logic clk10hz,
  output logic clk5hz,
  output logic tick10,
  output logic tick5,
  output logic frez
);

  localparam int unsigned DIV   = div_of(CLK_HZ);
  localparam int unsigned DIV_W = cnt_width(DIV);
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_too_small
      $error("chia_xung: CLK_HZ must be at least 40 so that DIV >= 2");
    end
  endgenerate

  logic [DIV_W-1:0] cnt;
  phase_e           ph;
  logic [1:0]       ph_bits;
  logic             deb;
  logic             tick20;

  chong_doi #(
    .DEB_CYC (DEB_CYC)
  ) u_chong_doi (
    .clk   (clk),
    .rst   (rst),
    .d_in  (frez_in),
    .d_out (deb)
  );

  assign tick20 = en & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      ph   <= PH_LOW;
      frez <= 1'b0;
    end else if (en) begin
      if (tick20) begin
        cnt <= '0;
        ph  <= next_phase(ph);
        // Wrap 3->0 takes both clocks low together: the only safe moment
        // for the downstream selector to switch. A deb update on this same
        // edge is picked up one full period later.
        if (ph == PH_BOTH) begin
          frez <= deb;
        end
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign ph_bits = ph;
  assign clk10hz = ph_bits[0];
  assign clk5hz  = ph_bits[1];

  // Ticks mark the cycle whose closing edge raises the respective clock.
  assign tick10 = tick20 & ~ph_bits[0];
  assign tick5  = tick20 & (ph == PH_10);

endmodule : chia_xung
`default_nettype wire

// File: tb/tb_chia_xung.sv
`default_nettype none
// ============================================================================
// Module  : tb_chia_xung
// Purpose : Self-checking bench for chia_xung with CLK_HZ=80 (DIV=4) and
//           DEB_CYC=3: directed scenarios with literal expectations plus a
//           randomized run compared every cycle against a behavioural model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_chia_xung;

  localparam int CLK_HZ  = 80;
  localparam int DEB_CYC = 3;
  localparam int DIV     = CLK_HZ / 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic frez_in = 1'b0;
  logic clk10hz, clk5hz, tick10, tick5, frez;

  int errors = 0;
  int checks = 0;

  chia_xung #(
    .CLK_HZ  (CLK_HZ),
    .DEB_CYC (DEB_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .frez_in (frez_in),
    .clk10hz (clk10hz),
    .clk5hz  (clk5hz),
    .tick10  (tick10),
    .tick5   (tick5),
    .frez    (frez)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n counts enabled cycles since reset; the phase is simply n/DIV mod 4.
  int m_n = 0;
  int m_deb = 0;
  int m_run = 0;
  int m_frez = 0;
  int m_hist1 = 0;
  int m_hist2 = 0;
  bit m_valid = 1'b0;

  task automatic model_step();
    if (rst) begin
      m_n = 0; m_deb = 0; m_run = 0; m_frez = 0;
      m_hist1 = 0; m_hist2 = 0; m_valid = 1'b1;
    end else begin
      if (en) begin
        if ((m_n + 1) % (4 * DIV) == 0) m_frez = m_deb;
        m_n++;
      end
      if (m_hist2 != m_deb) begin
        m_run++;
        if (m_run == DEB_CYC) begin
          m_deb = m_hist2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_hist2 = m_hist1;
      m_hist1 = int'(frez_in);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Tick counters used by directed checks.
  int nt10 = 0;
  int nt5 = 0;

  initial forever begin
    int ph;
    bool_t_dummy: begin end
    @(negedge clk);
    if (tick10 === 1'b1) nt10++;
    if (tick5 === 1'b1) nt5++;
    if (m_valid) begin
      ph = (m_n / DIV) % 4;
      check("clk10hz", int'(clk10hz), ph % 2);
      check("clk5hz", int'(clk5hz), ph / 2);
      check("tick10", int'(tick10),
            (en && (m_n % DIV == DIV - 1) && (ph % 2 == 0)) ? 1 : 0);
      check("tick5", int'(tick5),
            (en && (m_n % DIV == DIV - 1) && (ph == 1)) ? 1 : 0);
      check("frez", int'(frez), m_frez);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    int hold;
    rst = 1'b1; en = 1'b1; frez_in = 1'b0;
    step(); step();
    check("rst_clk10hz", int'(clk10hz), 0);
    check("rst_clk5hz", int'(clk5hz), 0);
    check("rst_tick10", int'(tick10), 0);
    check("rst_tick5", int'(tick5), 0);
    check("rst_frez", int'(frez), 0);

    // Free run after release; frez_in rises so deb flips on edge 16,
    // exactly the first 3->0 wrap: frez must wait until edge 32.
    rst = 1'b0;
    nt10 = 0; nt5 = 0;
    for (int e = 1; e <= 36; e++) begin
      step();
      case (e)
        3:  check("first_rise_pre", int'(clk10hz), 0);
        4:  begin
              check("first_rise", int'(clk10hz), 1);
              check("first_rise_c5", int'(clk5hz), 0);
            end
        8:  begin
              check("c10_low_e8", int'(clk10hz), 0);
              check("c5_high_e8", int'(clk5hz), 1);
            end
        11: frez_in = 1'b1;
        12: check("both_high_e12", int'(clk10hz & clk5hz), 1);
        16: begin
              check("simul_frez_hold", int'(frez), 0);
              check("wrap_clocks_low", int'(clk10hz | clk5hz), 0);
            end
        31: check("frez_pre_wrap", int'(frez), 0);
        32: begin
              check("frez_at_wrap", int'(frez), 1);
              check("frez_clocks_low", int'(clk10hz | clk5hz), 0);
              check("tick10_count", nt10, 4);
              check("tick5_count", nt5, 2);
            end
        36: check("pause_start_c10", int'(clk10hz), 1);
        default: ;
      endcase
    end

    // Enable pause while clk10hz is high.
    en = 1'b0;
    nt10 = 0; nt5 = 0;
    for (int i = 0; i < 10; i++) step();
    check("pause_hold_c10", int'(clk10hz), 1);
    check("pause_ticks", nt10 + nt5, 0);
    en = 1'b1;
    step(); step(); step();
    check("resume_still_high", int'(clk10hz), 1);
    step();
    check("resume_fall", int'(clk10hz), 0);

    // Reset mid-run while ph==3 and frez==1.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (clk10hz && clk5hz) found = 1'b1;
      else step();
    end
    check("find_ph3", int'(found), 1);
    check("pre_reset_frez", int'(frez), 1);
    rst = 1'b1; frez_in = 1'b0;
    step();
    check("midrst_outputs", int'({clk10hz, clk5hz, tick10, tick5, frez}), 0);
    rst = 1'b0;

    // Glitch shorter than the debounce window.
    step();
    frez_in = 1'b1; step(); step();
    frez_in = 1'b0;
    for (int i = 0; i < 40; i++) step();
    check("glitch_frez", int'(frez), 0);

    // Randomized run against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if (hold == 0) begin
        frez_in = $urandom_range(0, 1);
        hold = $urandom_range(1, 6);
      end else begin
        hold--;
      end
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_chia_xung
`default_nettype wire

// File: doc/chia_xung.md
CHIA_XUNG -- requirements
Module: chia_xung

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, SHALL give the input clock frequency in Hz.
REQ-002 Parameter DEB_CYC, default 500_000 (10 ms), SHALL give the debounce stability window in clk cycles.
REQ-003 Port clk  input  1  SHALL be the single system clock; all logic is in this domain.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port en  input  1  SHALL be the run enable; 0 freezes waveform generation.
REQ-006 Port frez_in  input  1  SHALL be the raw, asynchronous frequency-select switch (0 = 5 Hz, 1 = 10 Hz).
REQ-007 Port clk10hz  output  1  SHALL be a registered 10 Hz square wave with 50 % duty cycle.
REQ-008 Port clk5hz  output  1  SHALL be a registered 5 Hz square wave with 50 % duty cycle, phase-aligned to clk10hz.
REQ-009 Port tick10  output  1  SHALL be a one-cycle pulse on each clk10hz rising edge.
REQ-010 Port tick5  output  1  SHALL be a one-cycle pulse on each clk5hz rising edge.
REQ-011 Port frez  output  1  SHALL be the debounced select, updated only at safe switching points, for the downstream clock selector.

Function
REQ-012 The prescaler SHALL be defined as follows: DIV = CLK_HZ/20, integer division; counter cnt runs 0..DIV-1 and advances only when en=1; tick20 is asserted when cnt==DIV-1 and en=1, and cnt then wraps to 0.
REQ-013 On each tick20, the 2-bit phase counter ph SHALL advance modulo 4, with the new value visible on the next cycle.
REQ-014 Outputs SHALL be driven from ph as follows: clk10hz = ph[0] and clk5hz = ph[1], both registered; ph==0 means both outputs are low.
REQ-015 tick10 SHALL be high for exactly the one cycle in which ph changes 0->1 or 2->3; tick5 SHALL be high for exactly the one cycle in which ph changes 1->2.
REQ-016 When en=0, cnt, ph, clk10hz, clk5hz and frez SHALL hold; tick10 and tick5 SHALL be 0; the debouncer SHALL keep running.
REQ-017 When en returns to 1, counting SHALL resume from the held cnt with no phase skip.
REQ-018 frez_in SHALL pass through a 2-flop synchronizer before debouncing.
REQ-019 The debouncer SHALL maintain a stable-state register deb and a counter dcnt with these rules:
- When the synchronized value equals deb, dcnt clears to 0.
- Otherwise dcnt increments.
- When dcnt reaches DEB_CYC-1, deb takes the synchronized value and dcnt clears.
REQ-020 frez SHALL load the registered deb value only in the cycle in which ph wraps 3->0, so the select changes only while both clocks go low together.
REQ-021 If deb updates in the same cycle as a ph wrap, frez SHALL keep its old value and take the new value at the following wrap.
REQ-022 A frez_in pulse whose synchronized duration is shorter than DEB_CYC cycles SHALL NOT change deb or frez.
REQ-023 All counter widths SHALL be the minimum needed to hold DIV-1 and DEB_CYC-1; DIV SHALL be at least 2.

Reset
REQ-024 While rst=1 at a clk edge, the following SHALL be cleared to 0: cnt, ph, dcnt, deb, both synchronizer flops, clk10hz, clk5hz, tick10, tick5 and frez.
REQ-025 Reset asserted mid-period SHALL clear all state on the next edge, regardless of en.
REQ-026 After reset is released, the first tick20 SHALL occur DIV enabled cycles later.

Structure
REQ-027 The shared package chia_xung_pkg SHALL hold the default CLK_HZ and DEB_CYC values, the DIV derivation, and the $clog2-based counter-width constants.
REQ-028 The synchronizer and debouncer SHALL be one sub-module, chong_doi, with ports clk, rst, d_in, d_out and parameter DEB_CYC.
REQ-029 The prescaler, phase counter, tick generation and frez gating SHALL reside in chia_xung.

Verification (CLK_HZ=80 so DIV=4, DEB_CYC=3)
REQ-030 Free-running case: reset, then en=1 constantly -> clk10hz period is 8 cycles at 50 % duty; clk5hz period is 16 cycles; tick10 occurs once per 8 cycles; tick5 occurs once per 16 cycles; the first clk10hz rise occurs 4 cycles after reset release.
REQ-031 Select change: frez_in 0->1 held steady -> deb=1 after 2+3 cycles; frez rises only in the cycle ph wraps 3->0, at which point clk5hz=clk10hz=0.
REQ-032 Glitch rejection: frez_in high for 2 cycles, then low -> deb=0 and frez=0 throughout.
REQ-033 Enable pause: en=0 for 10 cycles while clk10hz=1 -> all outputs hold and ticks are 0; after en=1 the remaining high time is completed with no phase skip.
REQ-034 Reset mid-run: rst=1 for 1 cycle while frez=1 and ph=3 -> on the next cycle all outputs are 0 and frez=0.
REQ-035 Simultaneous events: deb 0->1 in the same cycle as a 3->0 wrap -> frez stays 0 and rises at the next wrap, 16 cycles later.
